alu_ctrl_mc: RTL and testbench
==============================

# alu_ctrl_mc

Parametrised, registered ALU controller for the EX stage of the pipelined CPU. It decodes `ALUOp_i`/`funct_i` into ALU control and jump-register signals one cycle after acceptance, adds MULT/DIV support with a multi-cycle busy sequence, a stall handshake toward ID, flush handling and illegal-opcode flagging. It sits between the main Decoder and the ALU / mult-div unit.

## Interface
- `FUNCT_W`, default 6: funct field width.
- `ALUOP_W`, default 3: ALUOp width.
- `CTRL_W`, default 4: ALU control width, minimum 4.
- `MD_CYCLES`, default 4: cycles a MULT/DIV holds the unit busy, minimum 1.
- `clk_i`  in  1: clock, rising edge.
- `rst_i`  in  1: reset, synchronous, active-low.
- `valid_i`  in  1: op present on `funct_i`/`ALUOp_i`.
- `funct_i`  in  FUNCT_W: R-type funct.
- `ALUOp_i`  in  ALUOP_W: op class from Decoder.
- `flush_i`  in  1: kill in-flight/accepted op.
- `ready_o`  out  1: controller can accept; ID stalls when low.
- `valid_o`  out  1: one-cycle pulse, outputs below are fresh.
- `ALUCtrl_o`  out  CTRL_W: ALU operation.
- `JumpReg_o`  out  1: jr decoded.
- `md_start_o`  out  1: one-cycle pulse starting the mult/div unit.
- `md_done_o`  out  1: one-cycle pulse, last busy cycle.
- `illegal_o`  out  1: undefined op, qualified by `valid_o`.

## Operation
- Accept when `valid_i & ready_o & ~flush_i`.
- ALUOp 0 (R-type), funct: 32 ADD→0010, 34 SUB→0110, 36 AND→0000, 37 OR→0001, 42 SLT→0111, 0 SLL→0011, 8 JR→0000 with JumpReg_o=1, 24 MULT→1000, 26 DIV→1001.
- ALUOp: 1 ADDI→0010, 2 SLTI→0111, 3 BEQ→0110, 4 LW/SW→0010, 5 ORI→0001, 6 ANDI→0000.
- ALUOp 7 or unlisted funct: ALUCtrl_o=1111 (NOP), illegal_o=1, JumpReg_o=0.
- Upper bits zero-extended when CTRL_W>4.
- FSM states:
  - IDLE: ready_o=1. Accepted MULT/DIV → MD_BUSY with cnt=MD_CYCLES-1. All other accepted ops stay in IDLE.
  - MD_BUSY: ready_o=0. cnt decrements each cycle. At cnt==0, md_done_o=1 and next state is IDLE.
- cnt width $clog2(MD_CYCLES+1), unsigned, never wraps.
- ALUCtrl_o and JumpReg_o hold their last value when valid_o=0. JumpReg_o clears on the next accepted non-jr op.

## Timing
- Latency 1: op accepted at edge t, so valid_o, ALUCtrl_o, JumpReg_o and illegal_o appear after edge t+1. md_start_o coincides with valid_o.
- MULT/DIV: ready_o is low for exactly MD_CYCLES cycles starting the cycle after acceptance. With MD_CYCLES=1, md_start_o and md_done_o pulse in the same cycle.
- Back-to-back non-MD ops: one accepted per cycle, ready_o stays 1.
- valid_i while ready_o=0: ignored. The Decoder holds the op until ready_o=1.
- flush_i has priority over a same-cycle valid_i (no accept). In MD_BUSY, flush_i forces IDLE next cycle with no md_done_o. flush_i in IDLE with no accept is a no-op.
- Reset (rst_i=0 at edge), from any state and including mid-MD:
  - state IDLE, cnt 0.
  - valid_o 0, ALUCtrl_o 0, JumpReg_o 0, md_start_o 0, md_done_o 0, illegal_o 0.
  - ready_o is forced 1 combinationally while rst_i=0.

## Structure
- Package `alu_ctrl_pkg`: ALUCtrl code constants, funct constants, ALUOp constants, FSM state typedef (IDLE, MD_BUSY).
- Sub-module `alu_ctrl_decode`: purely combinational funct/ALUOp → {ctrl, jr, is_md, illegal}. The top holds the FSM, counter and output registers.

## Test plan
- Reset then ADD: rst_i low 2 cycles, then valid_i with ALUOp=0, funct=32 → next cycle valid_o=1, ALUCtrl_o=0010, ready_o stays 1.
- Back-to-back SUB, SLT, ADDI(ALUOp=1), JR → four consecutive valid_o pulses with ALUCtrl_o 0110, 0111, 0010, 0000 and JumpReg_o=1 only on the fourth.
- MULT, MD_CYCLES=4:
  - valid_o, ALUCtrl_o=1000 and md_start_o pulse in the cycle after acceptance.
  - ready_o low for 4 cycles; md_done_o pulses in the 4th.
  - a held SUB is accepted on the first ready_o=1 cycle.
- Flush: DIV accepted, flush_i asserted in the 2nd busy cycle → IDLE next cycle, no md_done_o. Same-cycle valid_i and flush_i → no valid_o.
- Illegal and mid-op reset: ALUOp=7 → valid_o=1, illegal_o=1, ALUCtrl_o=1111. Then MULT followed by rst_i low mid-busy → all outputs 0, ready_o=1.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU controller: ALU control codes,
// funct/ALUOp values, FSM state constants and the decoder result struct.
package alu_ctrl_pkg;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SLL  = 4'b0011;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_MULT = 4'b1000;
  localparam logic [3:0] CTRL_DIV  = 4'b1001;
  localparam logic [3:0] CTRL_NOP  = 4'b1111;

  localparam int F_SLL  = 0;
  localparam int F_JR   = 8;
  localparam int F_MULT = 24;
  localparam int F_DIV  = 26;
  localparam int F_ADD  = 32;
  localparam int F_SUB  = 34;
  localparam int F_AND  = 36;
  localparam int F_OR   = 37;
  localparam int F_SLT  = 42;

  localparam int OP_RTYPE = 0;
  localparam int OP_ADDI  = 1;
  localparam int OP_SLTI  = 2;
  localparam int OP_BEQ   = 3;
  localparam int OP_LWSW  = 4;
  localparam int OP_ORI   = 5;
  localparam int OP_ANDI  = 6;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE    = 1'b0;
  localparam state_t ST_MD_BUSY = 1'b1;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       jr;
    logic       is_md;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational funct/ALUOp decoder; anything not recognised decodes to
// NOP with the illegal flag set.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 3
) (
  input  logic [FUNCT_W-1:0] funct,
  input  logic [ALUOP_W-1:0] alu_op,
  output dec_t               dec
);

  always_comb begin
    dec = '{ctrl: CTRL_NOP, jr: 1'b0, is_md: 1'b0, illegal: 1'b1};
    if (alu_op == ALUOP_W'(OP_RTYPE)) begin
      dec.illegal = 1'b0;
      case (funct)
        FUNCT_W'(F_ADD):  dec.ctrl = CTRL_ADD;
        FUNCT_W'(F_SUB):  dec.ctrl = CTRL_SUB;
        FUNCT_W'(F_AND):  dec.ctrl = CTRL_AND;
        FUNCT_W'(F_OR):   dec.ctrl = CTRL_OR;
        FUNCT_W'(F_SLT):  dec.ctrl = CTRL_SLT;
        FUNCT_W'(F_SLL):  dec.ctrl = CTRL_SLL;
        FUNCT_W'(F_JR): begin
          dec.ctrl = CTRL_AND;
          dec.jr   = 1'b1;
        end
        FUNCT_W'(F_MULT): begin
          dec.ctrl  = CTRL_MULT;
          dec.is_md = 1'b1;
        end
        FUNCT_W'(F_DIV): begin
          dec.ctrl  = CTRL_DIV;
          dec.is_md = 1'b1;
        end
        default: dec.illegal = 1'b1;
      endcase
    end else begin
      dec.illegal = 1'b0;
      case (alu_op)
        ALUOP_W'(OP_ADDI): dec.ctrl = CTRL_ADD;
        ALUOP_W'(OP_SLTI): dec.ctrl = CTRL_SLT;
        ALUOP_W'(OP_BEQ):  dec.ctrl = CTRL_SUB;
        ALUOP_W'(OP_LWSW): dec.ctrl = CTRL_ADD;
        ALUOP_W'(OP_ORI):  dec.ctrl = CTRL_OR;
        ALUOP_W'(OP_ANDI): dec.ctrl = CTRL_AND;
        default:           dec.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_mc.sv
// Registered ALU controller with a multi-cycle MULT/DIV busy sequence,
// stall handshake toward ID and flush handling.
module alu_ctrl_mc
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W   = 6,
  parameter int ALUOP_W   = 3,
  parameter int CTRL_W    = 4,
  parameter int MD_CYCLES = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic               flush_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic               JumpReg_o,
  output logic               md_start_o,
  output logic               md_done_o,
  output logic               illegal_o,
  output state_t             state_dbg
);

  localparam int CNT_W = $clog2(MD_CYCLES + 1);

  // Handshake: an op transfers on a clock edge where valid_i & ready_o are
  // both high and flush_i is low; the Decoder holds the op while ready_o=0.
  state_t           state;
  logic [CNT_W-1:0] cnt;
  dec_t             dec;
  logic             accept;

  assign ready_o   = ~rst_i | (state == ST_IDLE);
  assign accept    = valid_i & ready_o & ~flush_i;
  assign md_done_o = rst_i & (state == ST_MD_BUSY) & (cnt == '0) & ~flush_i;
  assign state_dbg = state;

  alu_ctrl_decode #(
    .FUNCT_W(FUNCT_W),
    .ALUOP_W(ALUOP_W)
  ) u_decode (
    .funct (funct_i),
    .alu_op(ALUOp_i),
    .dec   (dec)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      valid_o    <= 1'b0;
      ALUCtrl_o  <= '0;
      JumpReg_o  <= 1'b0;
      md_start_o <= 1'b0;
      illegal_o  <= 1'b0;
    end else begin
      valid_o    <= accept;
      md_start_o <= accept & dec.is_md;
      illegal_o  <= accept & dec.illegal;
      // Control outputs hold between accepted ops.
      if (accept) begin
        ALUCtrl_o <= CTRL_W'(dec.ctrl);
        JumpReg_o <= dec.jr;
      end
      case (state)
        ST_IDLE: begin
          if (accept && dec.is_md) begin
            state <= ST_MD_BUSY;
            cnt   <= CNT_W'(MD_CYCLES - 1);
          end
        end
        ST_MD_BUSY: begin
          if (flush_i || cnt == '0) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Bench for alu_ctrl_mc: directed scenarios followed by random traffic,
// compared against a cycle-level reference model of the controller.
module tb_alu_ctrl_mc;
  import alu_ctrl_pkg::*;

  localparam int MD_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       flush;
  logic [5:0] funct;
  logic [2:0] alu_op;
  logic       ready_o, valid_o, JumpReg_o, md_start_o, md_done_o, illegal_o;
  logic [3:0] ALUCtrl_o;
  state_t     state_dbg;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: remaining busy cycles plus last expected outputs.
  int         m_busy;
  logic       m_valid, m_jr, m_start, m_ill;
  logic [3:0] m_ctrl;

  always #5 clk = ~clk;

  alu_ctrl_mc #(
    .FUNCT_W(6), .ALUOP_W(3), .CTRL_W(4), .MD_CYCLES(MD_CYCLES)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .valid_i   (valid),
    .funct_i   (funct),
    .ALUOp_i   (alu_op),
    .flush_i   (flush),
    .ready_o   (ready_o),
    .valid_o   (valid_o),
    .ALUCtrl_o (ALUCtrl_o),
    .JumpReg_o (JumpReg_o),
    .md_start_o(md_start_o),
    .md_done_o (md_done_o),
    .illegal_o (illegal_o),
    .state_dbg (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {ctrl[3:0], jr, is_md, illegal} straight from the op table.
  function automatic logic [6:0] ref_op(input int op, input int f);
    case (op)
      0: case (f)
        32: return {4'b0010, 3'b000};
        34: return {4'b0110, 3'b000};
        36: return {4'b0000, 3'b000};
        37: return {4'b0001, 3'b000};
        42: return {4'b0111, 3'b000};
        0:  return {4'b0011, 3'b000};
        8:  return {4'b0000, 3'b100};
        24: return {4'b1000, 3'b010};
        26: return {4'b1001, 3'b010};
        default: return {4'b1111, 3'b001};
      endcase
      1: return {4'b0010, 3'b000};
      2: return {4'b0111, 3'b000};
      3: return {4'b0110, 3'b000};
      4: return {4'b0010, 3'b000};
      5: return {4'b0001, 3'b000};
      6: return {4'b0000, 3'b000};
      default: return {4'b1111, 3'b001};
    endcase
  endfunction

  task automatic step(input logic r, input logic v, input int op, input int f, input logic fl);
    logic [6:0] d;
    logic       acc;
    @(negedge clk);
    rst    = r;
    valid  = v;
    alu_op = op[2:0];
    funct  = f[5:0];
    flush  = fl;
    #1;
    check("ready", ready_o, (!r || m_busy == 0));
    check("md_done", md_done_o, (r && m_busy == 1 && !fl));
    d = ref_op(op, f);
    if (!r) begin
      m_busy = 0; m_valid = 0; m_ctrl = 0; m_jr = 0; m_start = 0; m_ill = 0;
    end else begin
      acc     = v && m_busy == 0 && !fl;
      m_valid = acc;
      m_start = acc && d[1];
      if (acc) begin
        m_ctrl = d[6:3];
        m_jr   = d[2];
        m_ill  = d[0];
      end
      if (m_busy > 0) m_busy = fl ? 0 : m_busy - 1;
      else if (acc && d[1]) m_busy = MD_CYCLES;
    end
    @(posedge clk);
    #1;
    check("valid", valid_o, m_valid);
    check("alu_ctrl", ALUCtrl_o, m_ctrl);
    check("jump_reg", JumpReg_o, m_jr);
    check("md_start", md_start_o, m_start);
    if (m_valid || !r) check("illegal", illegal_o, m_ill);
  endtask

  initial begin
    int legal_f[9] = '{0, 8, 24, 26, 32, 34, 36, 37, 42};
    int op, f;
    logic r, v, fl;
    rst = 1'b0; valid = 1'b0; flush = 1'b0; funct = '0; alu_op = '0;
    m_busy = 0; m_valid = 0; m_ctrl = 0; m_jr = 0; m_start = 0; m_ill = 0;

    // Reset, then ADD
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 32, 0);
    step(1, 0, 0, 0, 0);
    // Back-to-back SUB, SLT, ADDI, JR
    step(1, 1, 0, 34, 0);
    step(1, 1, 0, 42, 0);
    step(1, 1, 1, int'($urandom_range(0, 63)), 0);
    step(1, 1, 0, 8, 0);
    step(1, 0, 0, 0, 0);
    // MULT with a SUB held until ready returns
    step(1, 1, 0, 24, 0);
    repeat (5) step(1, 1, 0, 34, 0);
    step(1, 0, 0, 0, 0);
    // DIV flushed in its second busy cycle, then valid+flush together
    step(1, 1, 0, 26, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 32, 1);
    step(1, 0, 0, 0, 0);
    // Illegal op, then reset in the middle of a MULT
    step(1, 1, 7, 0, 0);
    step(1, 1, 0, 24, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    repeat (3000) begin
      r  = ($urandom_range(0, 99) >= 2);
      v  = ($urandom_range(0, 99) < 70);
      fl = ($urandom_range(0, 99) < 10);
      op = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7));
      f  = ($urandom_range(0, 99) < 80) ? legal_f[$urandom_range(0, 8)]
                                        : int'($urandom_range(0, 63));
      step(r, v, op, f, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
